// File: rtl/btn_port_pkg.sv
// btn_port shared definitions: register offsets and default debounce timing.
package btn_port_pkg;

  // Register select values on the peripheral bus address.
  typedef enum logic [1:0] {
    BTN_STATE = 2'd0,
    BTN_RISE  = 2'd1,
    BTN_FALL  = 2'd2,
    BTN_MASK  = 2'd3
  } btn_reg_e;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_PRESCALE   = 16;

endpackage

// File: rtl/btn_port_if.sv
// btn_port peripheral bus: chip select, write strobe, register address, data and irq.
interface btn_port_if #(
  parameter int WIDTH = 32
);
  logic             cs;
  logic             wen;
  logic [1:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             irq;

  modport master (output cs, wen, addr, wdata, input rdata, irq);
  modport slave  (input cs, wen, addr, wdata, output rdata, irq);
endinterface

// File: rtl/btn_port_deb.sv
// btn_port_deb: one input bit - two-flop synchroniser, sample history and
// debounced level, with single-cycle strobes when the debounced level changes.
module btn_port_deb
  import btn_port_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic pin,
  output logic filtered,
  output logic rise,
  output logic fall
);
  // The new sample plus HD older samples make DEB_CYCLES agreeing samples.
  localparam int HD = DEB_CYCLES - 1;

  logic          sync1_reg;
  logic          sync2_reg;
  logic [HD-1:0] hist_reg;
  logic          filt_reg;
  logic          accept;

  // Two-flop synchroniser; the first flop sees the raw pin with nothing in front of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
    end
  end

  // A new level is accepted when this sample and the whole history agree on it.
  assign accept = tick && (hist_reg == {HD{sync2_reg}}) && (sync2_reg != filt_reg);

  // Shift the sample into the history on each tick; update the filtered level on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_reg <= '0;
      filt_reg <= 1'b0;
    end else if (tick) begin
      hist_reg <= HD'({hist_reg, sync2_reg});
      if (accept) filt_reg <= sync2_reg;
    end
  end

  assign filtered = filt_reg;
  assign rise     = accept && sync2_reg;
  assign fall     = accept && !sync2_reg;

endmodule

// File: rtl/btn_port.sv
// btn_port: debounced input port with sticky rise/fall latches (write-1-to-clear).
// Define BTN_IRQ_EN to add the MASK register and a registered interrupt output.
module btn_port
  import btn_port_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int PRESCALE   = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin,
  btn_port_if.slave        bus
);
  logic             tick;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;
  logic [WIDTH-1:0] rise_clr;
  logic [WIDTH-1:0] fall_clr;
  logic [WIDTH-1:0] rdata;
  logic             wr;

  generate
    if (PRESCALE == 1) begin : g_no_pre
      assign tick = 1'b1;
    end else begin : g_pre
      localparam int CW = $clog2(PRESCALE);
      localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
      logic [CW-1:0] count_reg;

      // Free-running sample prescaler: 0..PRESCALE-1, tick on the last count.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) count_reg <= '0;
        else if (count_reg == LAST) count_reg <= '0;
        else count_reg <= count_reg + 1'b1;
      end

      assign tick = (count_reg == LAST);
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      btn_port_deb #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .pin      (pin[gi]),
        .filtered (filtered[gi]),
        .rise     (rise_evt[gi]),
        .fall     (fall_evt[gi])
      );
    end
  endgenerate

  assign wr       = bus.cs && bus.wen;
  assign rise_clr = (wr && bus.addr == BTN_RISE) ? bus.wdata : '0;
  assign fall_clr = (wr && bus.addr == BTN_FALL) ? bus.wdata : '0;

  // Sticky edge latches; a hardware set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_reg <= '0;
      fall_reg <= '0;
    end else begin
      rise_reg <= (rise_reg & ~rise_clr) | rise_evt;
      fall_reg <= (fall_reg & ~fall_clr) | fall_evt;
    end
  end

`ifdef BTN_IRQ_EN
  logic [WIDTH-1:0] mask_reg;
  logic             irq_reg;

  // Interrupt mask register and registered interrupt from masked pending edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      if (wr && bus.addr == BTN_MASK) mask_reg <= bus.wdata;
      irq_reg <= |((rise_reg | fall_reg) & mask_reg);
    end
  end

  assign bus.irq = irq_reg;
`else
  assign bus.irq = 1'b0;
`endif

  // Combinational read mux; the bus reads zero unless a read is selected.
  always_comb begin
    rdata = '0;
    if (bus.cs && !bus.wen) begin
      case (btn_reg_e'(bus.addr))
        BTN_STATE: rdata = filtered;
        BTN_RISE:  rdata = rise_reg;
        BTN_FALL:  rdata = fall_reg;
`ifdef BTN_IRQ_EN
        BTN_MASK:  rdata = mask_reg;
`else
        BTN_MASK:  rdata = '0;
`endif
        default:   rdata = '0;
      endcase
    end
  end

  assign bus.rdata = rdata;

endmodule

// File: tb/tb_btn_port.sv
// Directed bench for btn_port: main instance with PRESCALE=1/DEB_CYCLES=4 and a
// second narrow instance with PRESCALE=16 for the sample-rate window.
module tb_btn_port;
  logic        clk;
  logic        reset;
  logic [31:0] pin;
  logic [3:0]  pin16;
  int          errors;
  int          checks;
  logic [31:0] d;
  int          n;

  btn_port_if #(.WIDTH(32)) b ();
  btn_port_if #(.WIDTH(4))  b16 ();

  btn_port #(.WIDTH(32), .DEB_CYCLES(4), .PRESCALE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .pin   (pin),
    .bus   (b)
  );

  btn_port #(.WIDTH(4), .DEB_CYCLES(4), .PRESCALE(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .pin   (pin16),
    .bus   (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] data);
    b.cs = 1'b1; b.wen = 1'b0; b.addr = a;
    #1;
    data = b.rdata;
    b.cs = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] data);
    b.cs = 1'b1; b.wen = 1'b1; b.addr = a; b.wdata = data;
    @(posedge clk); #1;
    b.cs = 1'b0; b.wen = 1'b0; b.wdata = '0;
  endtask

  task automatic edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; pin = 32'hFFFF_FFFF; pin16 = 4'h0;
    b.cs = 1'b0; b.wen = 1'b0; b.addr = 2'd0; b.wdata = '0;
    b16.cs = 1'b1; b16.wen = 1'b0; b16.addr = 2'd0; b16.wdata = '0;

    // Reset with all pins high, then release between edges.
    edges(3);
    rd(2'd0, d); check("reset_state", d, 32'h0);
    check("reset_irq", {31'b0, b.irq}, 32'h0);
    #1 reset = 1'b0;
    edges(5);
    rd(2'd0, d); check("rel_state_e4", d, 32'h0);
    rd(2'd1, d); check("rel_rise_e4", d, 32'h0);
    edges(1);
    rd(2'd0, d); check("rel_state_e5", d, 32'hFFFF_FFFF);
    rd(2'd1, d); check("rel_rise_e5", d, 32'hFFFF_FFFF);
    rd(2'd2, d); check("rel_fall_e5", d, 32'h0);

    pin = 32'h0;
    edges(6);
    rd(2'd0, d); check("all_low_state", d, 32'h0);
    rd(2'd2, d); check("all_low_fall", d, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd1, d); check("clr_rise", d, 32'h0);
    rd(2'd2, d); check("clr_fall", d, 32'h0);

    // Three-sample glitch on bit 2 must be rejected.
    pin[2] = 1'b1;
    edges(3);
    pin[2] = 1'b0;
    edges(8);
    rd(2'd0, d); check("glitch_state", d, 32'h0);
    rd(2'd1, d); check("glitch_rise", d, 32'h0);

    // Held level on bit 2 is accepted at edge 5.
    pin[2] = 1'b1;
    edges(5);
    rd(2'd0, d); check("deb_state_e4", d, 32'h0);
    edges(1);
    rd(2'd0, d); check("deb_state_e5", d, 32'h4);
    rd(2'd1, d); check("deb_rise_e5", d, 32'h4);

    pin[0] = 1'b1;
    edges(6);
    rd(2'd1, d); check("rise_b0", d, 32'h5);
    wr(2'd0, 32'h0);
    rd(2'd0, d); check("state_ro", d, 32'h5);
    wr(2'd1, 32'h1);
    rd(2'd1, d); check("w1c_rise", d, 32'h4);

    pin[0] = 1'b0;
    edges(6);
    rd(2'd0, d); check("b0_low_state", d, 32'h4);
    rd(2'd2, d); check("b0_fall", d, 32'h1);

    // Clear bits 0 and 2 on the very edge bit 0 rises again: bit 0 stays set.
    pin[0] = 1'b1;
    edges(5);
    wr(2'd1, 32'h5);
    rd(2'd1, d); check("set_wins", d, 32'h1);
    rd(2'd0, d); check("set_wins_state", d, 32'h5);

    wr(2'd2, 32'hFFFF_FFFF);
    pin[2] = 1'b0;
    edges(6);
    rd(2'd2, d); check("fall_b2", d, 32'h4);
    rd(2'd1, d); check("fall_rise_kept", d, 32'h1);
    rd(2'd0, d); check("fall_state", d, 32'h1);

    // Bus returns zero when not selected or when writing.
    b.cs = 1'b0; b.wen = 1'b0; b.addr = 2'd1;
    #1; check("idle_rdata", b.rdata, 32'h0);
    b.cs = 1'b1; b.wen = 1'b1; b.wdata = 32'h0;
    #1; check("write_rdata", b.rdata, 32'h0);
    b.cs = 1'b0; b.wen = 1'b0;
    edges(1);

`ifdef BTN_IRQ_EN
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd3, 32'h4);
    edges(1);
    rd(2'd3, d); check("mask_rd", d, 32'h4);
    check("irq_idle", {31'b0, b.irq}, 32'h0);
    pin[2] = 1'b1;
    edges(6);
    rd(2'd1, d); check("irq_rise_set", d, 32'h4);
    check("irq_same_edge", {31'b0, b.irq}, 32'h0);
    edges(1);
    check("irq_assert", {31'b0, b.irq}, 32'h1);
    wr(2'd1, 32'h4);
    edges(1);
    check("irq_deassert", {31'b0, b.irq}, 32'h0);
`else
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, d); check("mask_absent", d, 32'h0);
    pin[2] = 1'b1;
    edges(7);
    rd(2'd1, d); check("noirq_rise", d, 32'h5);
    check("irq_tied", {31'b0, b.irq}, 32'h0);
`endif

    // Reset mid-debounce on bit 1; pins 1 and 2 high at release rise after normal latency.
    pin[1] = 1'b1;
    edges(2);
    reset = 1'b1;
    rd(2'd0, d); check("midrst_state", d, 32'h0);
    rd(2'd1, d); check("midrst_rise", d, 32'h0);
    edges(1);
    reset = 1'b0;
    edges(5);
    rd(2'd0, d); check("postrst_e4", d, 32'h0);
    edges(1);
    rd(2'd0, d); check("postrst_state", d, 32'h7);
    rd(2'd1, d); check("postrst_rise", d, 32'h7);

    // PRESCALE=16 instance: acceptance lands within the sampling window.
    pin16[0] = 1'b1;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (b16.rdata[0] === 1'b1) break;
    end
    $display("prescale acceptance after %0d clks", n);
    check("prescale_window", {31'b0, (n >= 50 && n <= 67)}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
